// File: rtl/bus_cycle_if.sv
// bus_cycle_if: CPU-side request/response and internal bus signals
// of the physical bus cycle sequencer.
interface bus_cycle_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_byte;
  logic [21:0] cpu_pa;
  logic [15:0] cpu_wdata;
  logic        mmu_abort;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_nxm;
  logic        cpu_odd;
  logic [21:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        bus_iopage;
  logic [15:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  cpu_rd,
    input  cpu_wr,
    input  cpu_byte,
    input  cpu_pa,
    input  cpu_wdata,
    input  mmu_abort,
    input  bus_rdata,
    input  bus_ack,
    output cpu_rdata,
    output cpu_done,
    output cpu_nxm,
    output cpu_odd,
    output bus_addr,
    output bus_rd,
    output bus_wr,
    output bus_be,
    output bus_wdata,
    output bus_iopage
  );

  modport slave (
    output cpu_rd,
    output cpu_wr,
    output cpu_byte,
    output cpu_pa,
    output cpu_wdata,
    output mmu_abort,
    output bus_rdata,
    output bus_ack,
    input  cpu_rdata,
    input  cpu_done,
    input  cpu_nxm,
    input  cpu_odd,
    input  bus_addr,
    input  bus_rd,
    input  bus_wr,
    input  bus_be,
    input  bus_wdata,
    input  bus_iopage
  );
endinterface

// File: rtl/bus_cycle.sv
// bus_cycle: runs one Unibus-style transfer per CPU request below the MMU.
// Suppresses aborted/odd accesses and times out non-existent addresses.
module bus_cycle #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  bus_cycle_if.master bif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CYCLE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [21:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic        iop_q, iop_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        nxm_q, nxm_d;
  logic        odd_q, odd_d;

  logic        req;
  logic        odd_word;
  logic [15:0] rd_align;

  assign req      = bif.cpu_rd | bif.cpu_wr;
  assign odd_word = ~bif.cpu_byte & bif.cpu_pa[0];

  // Latched byte enables tell which lane a byte read came from.
  always_comb begin
    rd_align = bif.bus_rdata;
    unique case (1'b1)
      be_q == 2'b10: rd_align = {8'h00, bif.bus_rdata[15:8]};
      be_q == 2'b01: rd_align = {8'h00, bif.bus_rdata[7:0]};
      default:       rd_align = bif.bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    iop_d   = iop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    nxm_d   = 1'b0;
    odd_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bif.mmu_abort) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (odd_word) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            odd_d   = 1'b1;
          end else begin
            state_d = S_CYCLE;
            cnt_d   = 8'd0;
            addr_d  = {bif.cpu_pa[21:1], 1'b0};
            iop_d   = &bif.cpu_pa[21:13];
            wr_d    = bif.cpu_wr;
            rd_d    = ~bif.cpu_wr;
            if (bif.cpu_byte) begin
              be_d    = bif.cpu_pa[0] ? 2'b10 : 2'b01;
              wdata_d = {2{bif.cpu_wdata[7:0]}};
            end else begin
              be_d    = 2'b11;
              wdata_d = bif.cpu_wdata;
            end
          end
        end
      end
      S_CYCLE: begin
        cnt_d = cnt_q + 8'd1;
        // Ack beats the timeout when both land in the same clock.
        if (bif.bus_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rdata_d = rd_align;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          nxm_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_REL;
      end
      S_REL: begin
        if (!req) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 22'd0;
      be_q    <= 2'b00;
      wdata_q <= 16'd0;
      iop_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 16'd0;
      done_q  <= 1'b0;
      nxm_q   <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      iop_q   <= iop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      nxm_q   <= nxm_d;
      odd_q   <= odd_d;
    end
  end

  assign bif.cpu_rdata  = rdata_q;
  assign bif.cpu_done   = done_q;
  assign bif.cpu_nxm    = nxm_q;
  assign bif.cpu_odd    = odd_q;
  assign bif.bus_addr   = addr_q;
  assign bif.bus_rd     = rd_q;
  assign bif.bus_wr     = wr_q;
  assign bif.bus_be     = be_q;
  assign bif.bus_wdata  = wdata_q;
  assign bif.bus_iopage = iop_q;

endmodule

// File: tb/tb_bus_cycle.sv
// tb_bus_cycle: randomized and directed checks of bus_cycle against
// a transaction-level reference model.
module tb_bus_cycle;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  bus_cycle_if bif();

  bus_cycle #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bif     (bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_rdata;

  typedef struct {
    logic        done;
    int          lat;
    int          strobes;
    logic        rd_seen;
    logic        wr_seen;
    logic        hold_bad;
    logic        nxm;
    logic        odd;
    logic [15:0] rdata;
    logic [21:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        iop;
    int          extra;
  } obs_t;

  typedef struct {
    logic        bus;
    logic        nxm;
    logic        odd;
    int          strobes;
    int          lat;
    logic [21:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        iop;
    logic [15:0] rdata;
  } exp_t;

  task automatic model(
    input  logic        wr,
    input  logic        byt,
    input  logic [21:0] pa,
    input  logic [15:0] wd,
    input  logic        abort,
    input  int          ack_n,
    input  logic [15:0] rd,
    output exp_t        e
  );
    e.odd   = !abort && !byt && pa[0];
    e.bus   = !abort && !e.odd;
    e.nxm   = e.bus && (ack_n < 1 || ack_n > TMO);
    e.strobes = !e.bus ? 0 : (e.nxm ? TMO : ack_n);
    e.lat   = 1 + e.strobes;
    e.addr  = pa - 22'(pa % 2);
    e.be    = !byt ? 2'd3 : (pa[0] ? 2'd2 : 2'd1);
    e.wd    = !byt ? wd : 16'((wd % 256) * 257);
    e.iop   = pa >= 22'h3FE000;
    if (e.bus && !e.nxm && !wr) begin
      if (!byt) m_rdata = rd;
      else if (pa[0]) m_rdata = rd / 256;
      else m_rdata = rd % 256;
    end
    e.rdata = m_rdata;
  endtask

  task automatic do_access(
    input  logic        wr,
    input  logic        byt,
    input  logic [21:0] pa,
    input  logic [15:0] wd,
    input  logic        abort,
    input  int          ack_n,
    input  logic [15:0] rd,
    input  int          hold,
    output obs_t        o
  );
    int cyc;
    o = '{default: '0};
    @(negedge clk);
    bif.cpu_wr    = wr;
    bif.cpu_rd    = !wr;
    bif.cpu_byte  = byt;
    bif.cpu_pa    = pa;
    bif.cpu_wdata = wd;
    bif.mmu_abort = abort;
    cyc = 0;
    while (!o.done && cyc < TMO + 16) begin
      @(negedge clk);
      cyc++;
      if (bif.bus_rd || bif.bus_wr) begin
        o.strobes++;
        o.rd_seen |= bif.bus_rd;
        o.wr_seen |= bif.bus_wr;
        if (o.strobes == 1) begin
          o.addr = bif.bus_addr;
          o.be   = bif.bus_be;
          o.wd   = bif.bus_wdata;
          o.iop  = bif.bus_iopage;
        end else if ({bif.bus_addr, bif.bus_be, bif.bus_wdata,
                      bif.bus_iopage} !== {o.addr, o.be, o.wd, o.iop}) begin
          o.hold_bad = 1'b1;
        end
        bif.cpu_pa    = 22'($urandom);
        bif.cpu_wdata = 16'($urandom);
        bif.bus_ack   = (o.strobes == ack_n);
        bif.bus_rdata = bif.bus_ack ? rd : 16'($urandom);
      end else begin
        bif.bus_ack = 1'b0;
      end
      if (bif.cpu_done) begin
        o.done  = 1'b1;
        o.lat   = cyc;
        o.nxm   = bif.cpu_nxm;
        o.odd   = bif.cpu_odd;
        o.rdata = bif.cpu_rdata;
      end
    end
    bif.bus_ack = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (bif.bus_rd || bif.bus_wr || bif.cpu_done) o.extra++;
    end
    bif.cpu_rd    = 1'b0;
    bif.cpu_wr    = 1'b0;
    bif.mmu_abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bif.cpu_rd    = 1'b0;
    bif.cpu_wr    = 1'b0;
    bif.cpu_byte  = 1'b0;
    bif.cpu_pa    = 22'd0;
    bif.cpu_wdata = 16'd0;
    bif.mmu_abort = 1'b0;
    bif.bus_rdata = 16'd0;
    bif.bus_ack   = 1'b0;
    reset_n = 1'b0;
    m_rdata = 16'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bif.bus_rd, bif.bus_wr, bif.cpu_done, bif.cpu_nxm,
         bif.cpu_odd, bif.bus_iopage} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000",
               {bif.bus_rd, bif.bus_wr, bif.cpu_done, bif.cpu_nxm,
                bif.cpu_odd, bif.bus_iopage});
    end
    n_tests++;
    if ({bif.bus_addr, bif.bus_be, bif.bus_wdata} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_bus got %h want 0",
               {bif.bus_addr, bif.bus_be, bif.bus_wdata});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bif.cpu_rdata !== 16'd0 || bif.cpu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got rdata=%h done=%b want 0 0",
               bif.cpu_rdata, bif.cpu_done);
    end
  endtask

  task automatic test_word_read;
    obs_t o;
    exp_t e;
    model(1'b0, 1'b0, 22'o001000, 16'd0, 1'b0, 3, 16'o123456, e);
    do_access(1'b0, 1'b0, 22'o001000, 16'd0, 1'b0, 3, 16'o123456, 0, o);
    n_tests++;
    if (o.strobes !== 3 || o.rd_seen !== 1'b1 || o.wr_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_strobe got %0d rd=%b wr=%b want 3 1 0",
               o.strobes, o.rd_seen, o.wr_seen);
    end
    n_tests++;
    if (o.be !== 2'b11 || o.addr !== 22'o001000) begin
      n_fail++;
      $display("FAIL wr_be got be=%b addr=%o want 11 1000", o.be, o.addr);
    end
    n_tests++;
    if (o.done !== 1'b1 || o.rdata !== 16'o123456 || o.lat !== 4) begin
      n_fail++;
      $display("FAIL wr_done got done=%b rdata=%o lat=%0d want 1 123456 4",
               o.done, o.rdata, o.lat);
    end
    n_tests++;
    if (o.nxm !== 1'b0 || o.odd !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_flags got nxm=%b odd=%b want 0 0", o.nxm, o.odd);
    end
  endtask

  task automatic test_byte_write;
    obs_t o;
    exp_t e;
    int   an;
    an = $urandom_range(1, 5);
    model(1'b1, 1'b1, 22'o001001, 16'o000252, 1'b0, an, 16'hFFFF, e);
    do_access(1'b1, 1'b1, 22'o001001, 16'o000252, 1'b0, an, 16'hFFFF, 0, o);
    n_tests++;
    if (o.be !== 2'b10 || o.wd !== 16'o125252 || o.addr !== 22'o001000) begin
      n_fail++;
      $display("FAIL bw_bus got be=%b wd=%o addr=%o want 10 125252 1000",
               o.be, o.wd, o.addr);
    end
    n_tests++;
    if (o.wr_seen !== 1'b1 || o.rd_seen !== 1'b0 || o.strobes !== an) begin
      n_fail++;
      $display("FAIL bw_strobe got wr=%b rd=%b n=%0d want 1 0 %0d",
               o.wr_seen, o.rd_seen, o.strobes, an);
    end
    n_tests++;
    if (o.rdata !== e.rdata || o.done !== 1'b1) begin
      n_fail++;
      $display("FAIL bw_rdata_hold got %h done=%b want %h 1",
               o.rdata, o.done, e.rdata);
    end
  endtask

  task automatic test_byte_read;
    obs_t o;
    exp_t e;
    model(1'b0, 1'b1, 22'o004001, 16'd0, 1'b0, 2, 16'hA55A, e);
    do_access(1'b0, 1'b1, 22'o004001, 16'd0, 1'b0, 2, 16'hA55A, 0, o);
    n_tests++;
    if (o.rdata !== 16'h00A5) begin
      n_fail++;
      $display("FAIL br_odd got %h want 00a5", o.rdata);
    end
    model(1'b0, 1'b1, 22'o004000, 16'd0, 1'b0, 1, 16'hA55A, e);
    do_access(1'b0, 1'b1, 22'o004000, 16'd0, 1'b0, 1, 16'hA55A, 0, o);
    n_tests++;
    if (o.rdata !== 16'h005A || o.be !== 2'b01) begin
      n_fail++;
      $display("FAIL br_even got %h be=%b want 005a 01", o.rdata, o.be);
    end
  endtask

  task automatic test_nxm;
    obs_t o;
    exp_t e;
    model(1'b0, 1'b0, 22'o17777776, 16'd0, 1'b0, 0, 16'h1234, e);
    do_access(1'b0, 1'b0, 22'o17777776, 16'd0, 1'b0, 0, 16'h1234, 0, o);
    n_tests++;
    if (o.iop !== 1'b1 || o.strobes !== TMO) begin
      n_fail++;
      $display("FAIL nxm_strobe got iop=%b n=%0d want 1 %0d",
               o.iop, o.strobes, TMO);
    end
    n_tests++;
    if (o.done !== 1'b1 || o.nxm !== 1'b1 || o.lat !== TMO + 1) begin
      n_fail++;
      $display("FAIL nxm_done got done=%b nxm=%b lat=%0d want 1 1 %0d",
               o.done, o.nxm, o.lat, TMO + 1);
    end
    n_tests++;
    if (o.rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL nxm_rdata_hold got %h want %h", o.rdata, e.rdata);
    end
    model(1'b0, 1'b0, 22'o17777776, 16'd0, 1'b0, TMO, 16'hBEEF, e);
    do_access(1'b0, 1'b0, 22'o17777776, 16'd0, 1'b0, TMO, 16'hBEEF, 0, o);
    n_tests++;
    if (o.nxm !== 1'b0 || o.rdata !== 16'hBEEF || o.strobes !== TMO) begin
      n_fail++;
      $display("FAIL nxm_lastack got nxm=%b rdata=%h n=%0d want 0 beef %0d",
               o.nxm, o.rdata, o.strobes, TMO);
    end
  endtask

  task automatic test_odd_abort;
    obs_t o;
    exp_t e;
    model(1'b0, 1'b0, 22'o000003, 16'd0, 1'b0, 1, 16'h7777, e);
    do_access(1'b0, 1'b0, 22'o000003, 16'd0, 1'b0, 1, 16'h7777, 0, o);
    n_tests++;
    if (o.strobes !== 0 || o.odd !== 1'b1 || o.lat !== 1) begin
      n_fail++;
      $display("FAIL odd got n=%0d odd=%b lat=%0d want 0 1 1",
               o.strobes, o.odd, o.lat);
    end
    model(1'b0, 1'b0, 22'o000003, 16'd0, 1'b1, 1, 16'h7777, e);
    do_access(1'b0, 1'b0, 22'o000003, 16'd0, 1'b1, 1, 16'h7777, 0, o);
    n_tests++;
    if (o.strobes !== 0 || o.odd !== 1'b0 || o.nxm !== 1'b0 ||
        o.lat !== 1) begin
      n_fail++;
      $display("FAIL abort got n=%0d odd=%b nxm=%b lat=%0d want 0 0 0 1",
               o.strobes, o.odd, o.nxm, o.lat);
    end
    n_tests++;
    if (o.rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL abort_rdata got %h want %h", o.rdata, e.rdata);
    end
  endtask

  task automatic test_hold_release;
    obs_t o;
    exp_t e;
    model(1'b1, 1'b0, 22'o002000, 16'h4321, 1'b0, 2, 16'h0, e);
    do_access(1'b1, 1'b0, 22'o002000, 16'h4321, 1'b0, 2, 16'h0, 12, o);
    n_tests++;
    if (o.extra !== 0 || o.done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_extra got %0d done=%b want 0 1", o.extra, o.done);
    end
    model(1'b0, 1'b0, 22'o002000, 16'h0, 1'b0, 1, 16'h5A5A, e);
    do_access(1'b0, 1'b0, 22'o002000, 16'h0, 1'b0, 1, 16'h5A5A, 0, o);
    n_tests++;
    if (o.strobes !== 1 || o.rdata !== e.rdata || o.lat !== e.lat) begin
      n_fail++;
      $display("FAIL hold_restart got n=%0d rdata=%h lat=%0d want 1 %h %0d",
               o.strobes, o.rdata, o.lat, e.rdata, e.lat);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    int strobes;
    dones   = 0;
    strobes = 0;
    @(negedge clk);
    bif.cpu_rd   = 1'b1;
    bif.cpu_wr   = 1'b0;
    bif.cpu_byte = 1'b0;
    bif.cpu_pa   = 22'o003000;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bif.bus_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got bus_rd=%b want 1", bif.bus_rd);
    end
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bif.bus_rd, bif.bus_wr, bif.cpu_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_drop got %b want 000",
               {bif.bus_rd, bif.bus_wr, bif.cpu_done});
    end
    bif.cpu_rd = 1'b0;
    m_rdata = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (TMO + 8) begin
      @(negedge clk);
      if (bif.cpu_done) dones++;
      if (bif.bus_rd || bif.bus_wr) strobes++;
    end
    n_tests++;
    if (dones !== 0 || strobes !== 0) begin
      n_fail++;
      $display("FAIL rstmid_after got done=%0d strobes=%0d want 0 0",
               dones, strobes);
    end
    n_tests++;
    if (bif.cpu_rdata !== 16'd0 || bif.bus_addr !== 22'd0) begin
      n_fail++;
      $display("FAIL rstmid_clear got rdata=%h addr=%o want 0 0",
               bif.cpu_rdata, bif.bus_addr);
    end
  endtask

  task automatic test_random;
    obs_t        o;
    exp_t        e;
    logic        wr, byt, ab;
    logic [21:0] pa;
    logic [15:0] wd, rd;
    int          an, sel, hold;
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      byt = 1'($urandom);
      ab  = ($urandom_range(0, 7) == 0);
      pa  = 22'($urandom);
      if ($urandom_range(0, 3) == 0) pa = {9'h1FF, 13'($urandom)};
      wd  = 16'($urandom);
      rd  = 16'($urandom);
      sel = $urandom_range(0, 9);
      an  = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 5);
      hold = $urandom_range(0, 3);
      model(wr, byt, pa, wd, ab, an, rd, e);
      do_access(wr, byt, pa, wd, ab, an, rd, hold, o);
      n_tests++;
      if (o.done !== 1'b1 || o.lat !== e.lat || o.strobes !== e.strobes) begin
        n_fail++;
        $display("FAIL rnd%0d_timing got done=%b lat=%0d n=%0d want 1 %0d %0d",
                 i, o.done, o.lat, o.strobes, e.lat, e.strobes);
      end
      n_tests++;
      if (o.nxm !== e.nxm || o.odd !== e.odd || o.rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL rnd%0d_resp got nxm=%b odd=%b rd=%h want %b %b %h",
                 i, o.nxm, o.odd, o.rdata, e.nxm, e.odd, e.rdata);
      end
      n_tests++;
      if (o.extra !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_release got %0d want 0", i, o.extra);
      end
      if (e.bus) begin
        n_tests++;
        if (o.addr !== e.addr || o.be !== e.be || o.wd !== e.wd ||
            o.iop !== e.iop) begin
          n_fail++;
          $display("FAIL rnd%0d_bus got %h %b %h %b want %h %b %h %b",
                   i, o.addr, o.be, o.wd, o.iop,
                   e.addr, e.be, e.wd, e.iop);
        end
        n_tests++;
        if (o.rd_seen !== !wr || o.wr_seen !== wr || o.hold_bad !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd%0d_dir got rd=%b wr=%b holdbad=%b want %b %b 0",
                   i, o.rd_seen, o.wr_seen, o.hold_bad, !wr, wr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_byte_read();
    test_nxm();
    test_odd_abort();
    test_hold_release();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle.md
# bus_cycle

Physical bus cycle sequencer sitting directly downstream of the MMU. It takes the 22-bit physical address and read/write request produced for the CPU and runs one Unibus-style transfer on the internal memory/iopage bus. It suppresses the cycle on an MMU abort or an odd word address, and times out non-existent addresses (NXM). It returns read data, byte-lane aligned, with a single-cycle completion pulse and error flags for the CPU trap logic.

## Interface
- TIMEOUT, 64: cycles in CYCLE without bus_ack before NXM is declared (legal range 2..255)
- clk  in  1  system clock, all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_rd  in  1  read request, level; held until cpu_done
- cpu_wr  in  1  write request, level; held until cpu_done; has priority if both are set
- cpu_byte  in  1  1 = byte access, 0 = word access
- cpu_pa  in  22  physical address from the MMU, stable while a request is held
- cpu_wdata  in  16  write data; byte writes use bits [7:0]
- mmu_abort  in  1  MMU abort for the current access, sampled in IDLE only
- cpu_rdata  out  16  read data, zero-extended for byte reads; valid with cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_nxm  out  1  asserted with cpu_done when the cycle timed out
- cpu_odd  out  1  asserted with cpu_done for a word access to an odd address
- bus_addr  out  22  word-aligned address {cpu_pa[21:1],0}
- bus_rd  out  1  bus read strobe, level for the whole CYCLE state
- bus_wr  out  1  bus write strobe, level for the whole CYCLE state
- bus_be  out  2  byte enables, [1] = high byte
- bus_wdata  out  16  write data, lane-replicated for byte writes
- bus_iopage  out  1  1 when cpu_pa[21:13] is all ones (top 8 KB)
- bus_rdata  in  16  read data, valid when bus_ack is high
- bus_ack  in  1  slave completion, may arrive in the first CYCLE clock

## Operation
- States: IDLE, CYCLE, DONE, RELEASE. Encoded in 2 bits; reset state is IDLE.
- IDLE, with cpu_rd or cpu_wr high, applies these checks in priority order:
  - mmu_abort=1: go to DONE with no bus cycle and no flags set. The CPU handles the abort itself.
  - Word access with cpu_pa[0]=1: go to DONE with cpu_odd=1 and no bus cycle.
  - Otherwise: latch bus_addr, bus_be, bus_wdata, bus_iopage and the direction; clear the timeout counter; go to CYCLE.
- Byte enables and write data:
  - Word access: bus_be=11, bus_wdata=cpu_wdata.
  - Byte access: bus_be = cpu_pa[0] ? 10 : 01, bus_wdata = {cpu_wdata[7:0], cpu_wdata[7:0]}.
- CYCLE:
  - bus_rd or bus_wr is high. The 8-bit counter increments every clock.
  - bus_ack=1: register the read data and go to DONE.
  - Otherwise, when the counter equals TIMEOUT-1: set nxm and go to DONE.
  - If bus_ack arrives in the timeout clock, ack wins and no NXM is reported.
- Read data alignment:
  - Word: cpu_rdata = bus_rdata.
  - Byte: cpu_rdata = {8'b0, cpu_pa[0] ? bus_rdata[15:8] : bus_rdata[7:0]}.
  - Write or NXM: cpu_rdata holds its previous value.
- DONE:
  - cpu_done=1 for exactly one clock; cpu_nxm and cpu_odd are valid only in this clock.
  - Strobes are low.
  - Always go to RELEASE.
- RELEASE: wait until cpu_rd=0 and cpu_wr=0, then go to IDLE. This prevents a held request from retriggering.
- Bus hold rule: bus_addr, bus_be and bus_wdata stay constant through CYCLE even if cpu_pa changes.

## Timing
- Reset (async, immediate):
  - State goes to IDLE.
  - All strobes, cpu_done, cpu_nxm, cpu_odd and bus_iopage are 0.
  - bus_addr, bus_be, bus_wdata, cpu_rdata and the counter are 0.
- Reset asserted mid-CYCLE drops strobes the same instant; no completion is ever reported for that access.
- All outputs are registered; no combinational path from cpu_* to bus_*.
- Latency, request seen in IDLE to cpu_done:
  - Acked cycle: 2 + (ack delay) clocks. Ack in the first CYCLE clock gives cpu_done 2 clocks after the request edge.
  - Abort or odd: cpu_done in the clock after the request edge.
  - NXM: 1 + TIMEOUT clocks, with strobes high for exactly TIMEOUT clocks.
- Back-to-back throughput: a new access can start no earlier than the clock after the request drops in RELEASE.

## Test plan
- Word read at pa 0o001000, bus_ack in 3rd CYCLE clock with rdata 0o123456:
  - bus_rd high 3 clocks, bus_be=11.
  - cpu_done pulse with cpu_rdata=0o123456, nxm=odd=0.
- Byte write at pa 0o001001, wdata 0o000252:
  - bus_be=10, bus_wdata=0o125252, bus_addr=0o001000, bus_wr high until ack.
- Byte read at odd pa with rdata 0xA55A: cpu_rdata=0x00A5. The same access at an even pa gives 0x005A.
- Word read at pa 0o17777776 with bus_ack never asserted, TIMEOUT=64:
  - bus_iopage=1, bus_rd high exactly 64 clocks.
  - cpu_done with cpu_nxm=1.
  - A second run with ack in the 64th clock reports no nxm.
- Word read at pa 0o000003: no strobe, cpu_done next clock with cpu_odd=1. With mmu_abort=1 instead: no strobe and no flags.
- Request held high after cpu_done: block stays in RELEASE with no new strobe. Then:
  - Drop the request, reassert it: a new cycle starts.
  - Pull reset_n low mid-CYCLE: strobes clear immediately and no cpu_done is produced.
